// File: rtl/cal_acc_master_pkg.sv
// Shared arbitration codes, op-mode codes and FSM state type
// for the accelerator bus master.
package cal_acc_master_pkg;

  localparam logic ARB_CPU = 1'b0;
  localparam logic ARB_ACC = 1'b1;

  localparam logic [1:0] OP_COPY = 2'b00;
  localparam logic [1:0] OP_INV  = 2'b01;
  localparam logic [1:0] OP_THR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WB,
    S_YIELD,
    S_DONE
  } state_t;

endpackage

// File: rtl/cal_acc_master_pix_op.sv
// Per-pixel transform: copy, invert or binary threshold.
// Unused op code 11 behaves as copy.
import cal_acc_master_pkg::*;

module cal_pix_op #(
  parameter int DW = 8
) (
  input  logic [1:0]    op_mode,
  input  logic [DW-1:0] thresh,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] f
);

  always_comb begin
    f = d;
    unique case (1'b1)
      (op_mode == OP_INV): f = ~d;
      (op_mode == OP_THR): f = (d >= thresh) ? '1 : '0;
      default:             f = d;
    endcase
  end

endmodule

// File: rtl/cal_acc_master.sv
// Accelerator bus master: arbitrates for pixel memory and streams
// a transformed block from src to dst, yielding after each burst.
import cal_acc_master_pkg::*;

module cal_acc_master #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16,
  parameter int YIELD_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  input  logic [1:0]    op_mode,
  input  logic [DW-1:0] thresh,
  output logic          busy,
  output logic          done,
  output logic          acc_req,
  input  logic          arb_res,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int YW = $clog2(YIELD_CYC + 1);

  state_t        state, nxt;
  logic [AW-1:0] src_q, dst_q, len_q;
  logic [1:0]    op_q;
  logic [DW-1:0] thr_q;
  logic [AW:0]   idx, idx_nx;
  logic [BW-1:0] bcnt, bcnt_nx;
  logic [YW-1:0] ycnt;
  logic [DW-1:0] pix;

  assign idx_nx  = idx + (AW+1)'(1);
  assign bcnt_nx = bcnt + BW'(1);

  cal_pix_op #(.DW(DW)) u_op (
    .op_mode (op_q),
    .thresh  (thr_q),
    .d       (mem_rdata),
    .f       (pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      op_q  <= '0;
      thr_q <= '0;
      idx   <= '0;
      bcnt  <= '0;
      ycnt  <= '0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE: if (start) begin
          src_q <= src_addr;
          dst_q <= dst_addr;
          len_q <= len;
          op_q  <= op_mode;
          thr_q <= thresh;
          idx   <= '0;
          bcnt  <= '0;
        end
        S_WB: begin
          idx  <= idx_nx;
          bcnt <= bcnt_nx;
          ycnt <= '0;
        end
        S_YIELD: begin
          bcnt <= '0;
          ycnt <= ycnt + YW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:
        if (start) nxt = (len != '0) ? S_REQ : S_DONE;
      S_REQ:
        if (arb_res == ARB_ACC) nxt = S_RD;
      S_RD:
        nxt = S_WB;
      S_WB:
        if (idx_nx == {1'b0, len_q})      nxt = S_DONE;
        else if (bcnt_nx == BW'(MAX_BURST)) nxt = S_YIELD;
        else                                nxt = S_RD;
      S_YIELD:
        if (ycnt == YW'(YIELD_CYC - 1)) nxt = S_REQ;
      S_DONE:
        nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    acc_req   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_REQ: begin
        busy    = 1'b1;
        acc_req = 1'b1;
      end
      S_RD: begin
        busy     = 1'b1;
        acc_req  = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = src_q + idx[AW-1:0];
      end
      S_WB: begin
        busy      = 1'b1;
        acc_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = dst_q + idx[AW-1:0];
        mem_wdata = pix;
      end
      S_YIELD: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cal_acc_master.sv
// Directed bench: memory, CPU/ACC arbiter model and bus monitor
// around cal_acc_master with MAX_BURST=4, YIELD_CYC=2.
module tb_cal_acc_master;

  localparam logic ACC = 1'b1;
  localparam logic CPU = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic [1:0]  op_mode = '0;
  logic [7:0]  thresh = '0;
  logic        busy, done, acc_req, arb_res;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        cpu_req = 1'b0;
  logic        owner;
  logic [7:0]  mem [0:65535];
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  logic        clr = 1'b0;
  int          done_cnt, busy_cnt, viol, cur_gap;
  logic        acc_seen, cpu_seen;
  int          gaps[$];
  logic [15:0] rd_log[$], wr_log[$];

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cal_acc_master #(
    .AW(16), .DW(8), .MAX_BURST(4), .YIELD_CYC(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src),
    .dst_addr  (dst),
    .len       (len),
    .op_mode   (op_mode),
    .thresh    (thresh),
    .busy      (busy),
    .done      (done),
    .acc_req   (acc_req),
    .arb_res   (arb_res),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Arbiter: never revokes from the ACC while it requests.
  always @(posedge clk) begin
    if (rst) owner <= ACC;
    else if (owner == ACC && !acc_req && cpu_req) owner <= CPU;
    else if (owner == CPU && !cpu_req) owner <= ACC;
  end
  assign arb_res = owner;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (clr) begin
      done_cnt <= 0;
      busy_cnt <= 0;
      viol     <= 0;
      cur_gap  <= 0;
      acc_seen <= 1'b0;
      cpu_seen <= 1'b0;
      gaps.delete();
      rd_log.delete();
      wr_log.delete();
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (acc_req) acc_seen <= 1'b1;
      if (busy && arb_res == CPU) cpu_seen <= 1'b1;
      if ((mem_rd || mem_wr) && !(acc_req && arb_res == ACC))
        viol <= viol + 1;
      if (busy && !acc_req) cur_gap <= cur_gap + 1;
      else if (cur_gap != 0) begin
        gaps.push_back(cur_gap);
        cur_gap <= 0;
      end
      if (mem_rd) rd_log.push_back(mem_addr);
      if (mem_wr) wr_log.push_back(mem_addr);
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(logic [15:0] a, logic [7:0] d);
    pl_we = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic go(logic [15:0] s, logic [15:0] d, logic [15:0] l,
                    logic [1:0] op, logic [7:0] th);
    src = s;
    dst = d;
    len = l;
    op_mode = op;
    thresh = th;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk(tag, {31'd0, done}, 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_cycles(int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [7:0] ex_inv [4];
    logic [7:0] ex_thr [4];
    int k;
    ex_inv = '{8'hFF, 8'h80, 8'h7F, 8'h00};
    ex_thr = '{8'h00, 8'h00, 8'hFF, 8'hFF};

    @(negedge clk);
    poke(16'h0010, 8'h11);
    poke(16'h0011, 8'h22);
    poke(16'h0012, 8'h33);
    poke(16'h0013, 8'h44);
    poke(16'h0020, 8'h00);
    poke(16'h0021, 8'h7F);
    poke(16'h0022, 8'h80);
    poke(16'h0023, 8'hFF);
    for (int i = 0; i < 10; i++) poke(16'h0300 + 16'(i), 8'h50 + 8'(i));
    for (int i = 0; i < 8; i++)  poke(16'h0800 + 16'(i), 8'hC0 + 8'(i));
    poke(16'hFFFE, 8'hA1);
    poke(16'hFFFF, 8'hA2);
    poke(16'h0000, 8'hA3);
    poke(16'h0001, 8'hA4);
    chk("reset_outputs",
        {busy, done, acc_req, mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
    rst = 1'b0;
    clear();

    // Copy, no contention
    go(16'h0010, 16'h0100, 16'd4, 2'b00, 8'h00);
    wait_done("copy_done");
    chk("copy_px0", mem[16'h0100], 8'h11);
    chk("copy_px1", mem[16'h0101], 8'h22);
    chk("copy_px2", mem[16'h0102], 8'h33);
    chk("copy_px3", mem[16'h0103], 8'h44);
    chk("copy_done_cnt", done_cnt, 1);
    chk("copy_busy_cycles", busy_cnt, 9);
    chk("copy_viol", viol, 0);

    // Invert and threshold
    go(16'h0020, 16'h0120, 16'd4, 2'b01, 8'h00);
    wait_done("inv_done");
    for (int i = 0; i < 4; i++)
      chk($sformatf("inv_px%0d", i), mem[16'h0120 + 16'(i)], ex_inv[i]);
    go(16'h0020, 16'h0140, 16'd4, 2'b10, 8'h80);
    wait_done("thr_done");
    for (int i = 0; i < 4; i++)
      chk($sformatf("thr_px%0d", i), mem[16'h0140 + 16'(i)], ex_thr[i]);

    // Contention and yield
    clear();
    go(16'h0300, 16'h0400, 16'd10, 2'b00, 8'h00);
    cpu_req = 1'b1;
    for (k = 0; k < 100; k++) begin
      if (arb_res == CPU) break;
      @(negedge clk);
    end
    chk("yield_cpu_grant", {31'd0, arb_res}, {31'd0, CPU});
    wait_cycles(6);
    chk("yield_acc_waits", {31'd0, acc_req}, 32'd1);
    chk("yield_no_strobes", wr_log.size(), 4);
    cpu_req = 1'b0;
    wait_done("yield_done");
    for (int i = 0; i < 10; i++)
      chk($sformatf("yield_px%0d", i), mem[16'h0400 + 16'(i)], 8'h50 + 8'(i));
    chk("yield_gap_count", gaps.size(), 2);
    if (gaps.size() == 2) begin
      chk("yield_gap0", gaps[0], 2);
      chk("yield_gap1", gaps[1], 2);
    end
    chk("yield_resume_addr", (wr_log.size() > 4) ? wr_log[4] : 16'h0, 16'h0404);
    chk("yield_cpu_seen", {31'd0, cpu_seen}, 32'd1);
    chk("yield_viol", viol, 0);

    // Grant blocked
    cpu_req = 1'b1;
    wait_cycles(3);
    clear();
    go(16'h0010, 16'h0500, 16'd2, 2'b00, 8'h00);
    wait_cycles(8);
    chk("blocked_acc_req", {31'd0, acc_req}, 32'd1);
    chk("blocked_no_rd", rd_log.size(), 0);
    chk("blocked_no_wr", wr_log.size(), 0);
    cpu_req = 1'b0;
    wait_done("blocked_done");
    chk("blocked_px0", mem[16'h0500], 8'h11);
    chk("blocked_px1", mem[16'h0501], 8'h22);

    // Zero length
    clear();
    go(16'h0010, 16'h0510, 16'd0, 2'b00, 8'h00);
    chk("len0_done_next", {31'd0, done}, 32'd1);
    wait_cycles(3);
    chk("len0_no_acc_req", {31'd0, acc_seen}, 32'd0);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_no_wr", wr_log.size(), 0);

    // Reset mid-burst
    clear();
    go(16'h0800, 16'h0900, 16'd8, 2'b00, 8'h00);
    for (k = 0; k < 100; k++) begin
      if (wr_log.size() >= 2) break;
      @(negedge clk);
    end
    chk("rst_two_pixels", wr_log.size(), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outputs",
        {busy, done, acc_req, mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
    rst = 1'b0;
    wait_cycles(3);
    chk("rst_no_done", done_cnt, 0);
    go(16'h0020, 16'h0600, 16'd3, 2'b00, 8'h00);
    wait_done("rst_new_done");
    chk("rst_new_px0", mem[16'h0600], 8'h00);
    chk("rst_new_px1", mem[16'h0601], 8'h7F);
    chk("rst_new_px2", mem[16'h0602], 8'h80);

    // Address wrap and start while busy
    clear();
    go(16'hFFFE, 16'h0700, 16'd4, 2'b00, 8'h00);
    wait_cycles(3);
    go(16'h1234, 16'h0780, 16'd1, 2'b01, 8'h00);
    wait_done("wrap_done");
    chk("wrap_rd_count", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("wrap_rd0", rd_log[0], 16'hFFFE);
      chk("wrap_rd1", rd_log[1], 16'hFFFF);
      chk("wrap_rd2", rd_log[2], 16'h0000);
      chk("wrap_rd3", rd_log[3], 16'h0001);
    end
    chk("wrap_px0", mem[16'h0700], 8'hA1);
    chk("wrap_px3", mem[16'h0703], 8'hA4);
    wait_cycles(4);
    chk("wrap_done_cnt", done_cnt, 1);
    chk("wrap_viol", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
